// File: rtl/memory_bank_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : memory_bank_arbiter_if
//  Description : Bundle between two memory requesters, the arbiter and one
//                single-port memory_bank.
//                  req/we/lock/addr/wdata   requester -> arbiter
//                  ack/rdata/rvalid         arbiter   -> requester
//                  mem_addr/read/write/
//                  mem_data_in              arbiter   -> memory_bank
//                  mem_data_out             memory_bank -> arbiter
//                slave  : arbiter side
//                master : requester/memory side (testbench, system glue)
//  Revision    : 1.0 - initial release
// ============================================================================
interface memory_bank_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 512
);
  localparam int AW = $clog2(DEPTH);

  logic                  req0,   req1;
  logic                  we0,    we1;
  logic                  lock0,  lock1;
  logic [AW-1:0]         addr0,  addr1;
  logic [DATA_WIDTH-1:0] wdata0, wdata1;
  logic                  ack0,   ack1;
  logic [DATA_WIDTH-1:0] rdata0, rdata1;
  logic                  rvalid0, rvalid1;

  logic [AW-1:0]         mem_addr;
  logic                  mem_read;
  logic                  mem_write;
  logic [DATA_WIDTH-1:0] mem_data_in;
  logic [DATA_WIDTH-1:0] mem_data_out;

  modport slave (
    input  req0, req1, we0, we1, lock0, lock1,
    input  addr0, addr1, wdata0, wdata1,
    input  mem_data_out,
    output ack0, ack1, rdata0, rdata1, rvalid0, rvalid1,
    output mem_addr, mem_read, mem_write, mem_data_in
  );

  modport master (
    output req0, req1, we0, we1, lock0, lock1,
    output addr0, addr1, wdata0, wdata1,
    output mem_data_out,
    input  ack0, ack1, rdata0, rdata1, rvalid0, rvalid1,
    input  mem_addr, mem_read, mem_write, mem_data_in
  );
endinterface
`default_nettype wire

// File: rtl/memory_bank_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : memory_bank_arbiter
//  Description : Two-port round-robin arbiter/sequencer in front of one
//                single-port memory_bank (1-cycle registered read). At most
//                one operation per cycle; a port holding lock keeps the grant
//                for up to MAX_BURST consecutive cycles under contention.
//                Read data returns to the issuing port 2 cycles after ack.
//  Ports       : clk   - system clock, rising edge
//                rst_n - synchronous active-low reset
//                bus   - memory_bank_arbiter_if.slave (requests, acks,
//                        read return, memory_bank drive/return)
//  Revision    : 1.0 - initial release
// ============================================================================
module memory_bank_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 512,
  parameter int MAX_BURST  = 16
) (
  input  wire                      clk,
  input  wire                      rst_n,
  memory_bank_arbiter_if.slave     bus
);

  localparam int            AW          = $clog2(DEPTH);
  localparam int            c_bw        = $clog2(MAX_BURST + 1);
  localparam logic [c_bw-1:0] c_max_burst = c_bw'(MAX_BURST);
  localparam logic [c_bw-1:0] c_one       = c_bw'(1);

  logic                  r_last_grant;
  logic [c_bw-1:0]       r_burst_cnt;
  logic                  r_pend0, r_pend1;
  logic                  r_rvalid0, r_rvalid1;
  logic [DATA_WIDTH-1:0] r_rdata0, r_rdata1;

  logic                  w_gnt_valid;
  logic                  w_gnt;
  logic                  w_lock_last;
  logic                  w_we;
  logic [AW-1:0]         w_addr;
  logic [DATA_WIDTH-1:0] w_wdata;

  assign w_lock_last = r_last_grant ? bus.lock1 : bus.lock0;

  // Under contention the last winner keeps the grant only while it asks for
  // a lock and has not used up its burst allowance; otherwise alternate.
  always_comb begin
    w_gnt_valid = 1'b0;
    w_gnt       = 1'b0;
    if (bus.req0 && bus.req1) begin
      w_gnt_valid = 1'b1;
      if (w_lock_last && (r_burst_cnt < c_max_burst))
        w_gnt = r_last_grant;
      else
        w_gnt = ~r_last_grant;
    end else if (bus.req0) begin
      w_gnt_valid = 1'b1;
      w_gnt       = 1'b0;
    end else if (bus.req1) begin
      w_gnt_valid = 1'b1;
      w_gnt       = 1'b1;
    end
    if (!rst_n)
      w_gnt_valid = 1'b0;
  end

  assign w_we    = w_gnt ? bus.we1    : bus.we0;
  assign w_addr  = w_gnt ? bus.addr1  : bus.addr0;
  assign w_wdata = w_gnt ? bus.wdata1 : bus.wdata0;

  assign bus.ack0        = w_gnt_valid & ~w_gnt;
  assign bus.ack1        = w_gnt_valid &  w_gnt;
  assign bus.mem_addr    = w_addr;
  assign bus.mem_data_in = w_wdata;
  assign bus.mem_write   = w_gnt_valid &  w_we;
  assign bus.mem_read    = w_gnt_valid & ~w_we;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
      r_burst_cnt  <= '0;
      r_pend0      <= 1'b0;
      r_pend1      <= 1'b0;
      r_rvalid0    <= 1'b0;
      r_rvalid1    <= 1'b0;
      r_rdata0     <= '0;
      r_rdata1     <= '0;
    end else begin
      if (w_gnt_valid) begin
        if (w_gnt == r_last_grant) begin
          // Saturates so an uncontested requester is never throttled.
          if (r_burst_cnt < c_max_burst)
            r_burst_cnt <= r_burst_cnt + c_one;
        end else begin
          r_burst_cnt  <= c_one;
          r_last_grant <= w_gnt;
        end
      end

      // Memory output is valid the cycle after the read is issued.
      r_pend0   <= bus.mem_read & ~w_gnt;
      r_pend1   <= bus.mem_read &  w_gnt;
      r_rvalid0 <= r_pend0;
      r_rvalid1 <= r_pend1;
      if (r_pend0)
        r_rdata0 <= bus.mem_data_out;
      if (r_pend1)
        r_rdata1 <= bus.mem_data_out;
    end
  end

  assign bus.rvalid0 = r_rvalid0;
  assign bus.rvalid1 = r_rvalid1;
  assign bus.rdata0  = r_rdata0;
  assign bus.rdata1  = r_rdata1;

endmodule
`default_nettype wire

// File: doc/memory_bank_arbiter.md
Name: memory_bank_arbiter

Overview:
Two-requester arbiter and sequencer for one single-port memory_bank instance (write-priority, 1-cycle registered read) in the sdspi system test. Typical use: port 0 is the SD block loader filling 512-byte sectors, port 1 is the host/checker reading them back. Issues at most one memory operation per cycle, chosen by round-robin with optional bounded locking for bursts, and returns read data to the originating port with a fixed latency.

Parameters:
DATA_WIDTH, 8, word width; must match memory_bank.
DEPTH, 512, memory words; address width AW = $clog2(DEPTH).
MAX_BURST, 16, max consecutive grants a locked port keeps while the other port is requesting; must be >= 1.

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
req0 / req1  input  1  port requests an operation this cycle
we0 / we1  input  1  1 = write, 0 = read; sampled with req
lock0 / lock1  input  1  port asks to keep the grant on conflict (burst)
addr0 / addr1  input  AW  word address
wdata0 / wdata1  input  DATA_WIDTH  write data
ack0 / ack1  output  1  combinational; operation accepted this cycle
rdata0 / rdata1  output  DATA_WIDTH  registered read data, held until the port's next read returns
rvalid0 / rvalid1  output  1  registered one-cycle pulse; rdata valid
mem_addr  output  AW  to memory_bank addr
mem_read  output  1  to memory_bank read
mem_write  output  1  to memory_bank write
mem_data_in  output  DATA_WIDTH  to memory_bank data_in
mem_data_out  input  DATA_WIDTH  from memory_bank data_out

Behaviour:
- Reset (rst_n=0 at an edge): rdata0/1=0, rvalid0/1=0, read-pending flags=0, last_grant=1 (port 0 wins the first conflict), burst_cnt=0. While rst_n=0, ack0/1, mem_read and mem_write are forced to 0. mem_addr and mem_data_in are don't-care when no operation is issued.
- Grant decision, combinational in cycle C:
  - Only one req high: that port is granted.
  - Both high, port i last granted, lock_i=1 and burst_cnt < MAX_BURST: port i is granted.
  - Both high, otherwise: the port not last granted is granted.
  - Neither high: no grant; memory ports idle.
- Granted port g in cycle C: ack_g=1, mem_addr=addr_g, mem_data_in=wdata_g, mem_write=we_g, mem_read=!we_g. Exactly one of mem_read/mem_write is high. The non-granted port sees ack=0 and must hold its request.
- State update at the end of C:
  - If g equals last_grant, burst_cnt = min(burst_cnt+1, MAX_BURST). Otherwise burst_cnt=1 and last_grant=g.
  - Idle cycles leave last_grant and burst_cnt unchanged.
  - burst_cnt does not gate a requester that is running uncontested.
- Read pipeline:
  - Read granted in C sets pend_g at the end of C.
  - In C+1, mem_data_out is valid. At the end of C+1, rdata_g <= mem_data_out, rvalid_g <= 1.
  - rvalid_g is high during C+2 only. Read latency is 2 cycles from ack.
  - Back-to-back reads (including alternating ports) are fully pipelined at 1 op/cycle.
  - Writes never produce rvalid.
- Write-after-read and read-after-write to the same address are ordered by grant order. A read granted in the cycle after a write to the same address returns the new data.
- Reset mid-operation: pending reads are discarded and no rvalid is emitted after reset deasserts.
- rdata_i changes only on that port's own read completion. The other port's traffic never alters it.

Test Plan:
1. Reset then port0 writes 0xA5 @0x010 with req1=0 -> ack0=1 in the same cycle, mem_write=1, mem_addr=0x010, mem_data_in=0xA5; no rvalid.
2. Port1 reads @0x010 after test 1 -> ack1=1, mem_read=1; rvalid1=1 exactly 2 cycles later with rdata1=0xA5; rdata1 holds 0xA5 afterwards; rvalid0 stays 0.
3. First conflict after reset, both ports read (0x001 / 0x002, memory preloaded 0x11 / 0x22), lock=0 -> port0 granted first, port1 next cycle; rvalid0 then rvalid1 on consecutive cycles with 0x11 / 0x22; grants alternate 0,1,0,1 while both hold req.
4. MAX_BURST=4, port0 lock0=1 writing 0x100..0x10F, req1 held as a read -> port0 gets 4 consecutive acks, then port1 gets 1, then port0 gets 4 again; no ack is lost.
5. Port0 reads @0x020 and rst_n=0 on the next cycle -> rvalid0 never asserts; after reset rdata0=0, mem_read=0, mem_write=0.
6. Write 0x3C @0x1FF then an immediate port1 read @0x1FF -> rdata1=0x3C; top address reached with no wrap error.
